// File: rtl/snn_pkg.sv
// Shared types and default sizing for the SNN SoC event path.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ctrl_state_t;

    localparam int ADDR_W_DEF      = 4;
    localparam int NUM_WEIGHTS_DEF = 8;

endpackage

// File: rtl/snn_event_controller.sv
// Event sequencer: latches a spike source address and sweeps its weight row,
// one write-enable cycle per weight, then pulses done and returns to idle.
module snn_event_controller
    import snn_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_WEIGHTS = NUM_WEIGHTS_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             event_addr,
    input  logic                          event_received,
    output logic                          event_ready,
    output logic                          weight_w_en,
    output logic [ADDR_W+$clog2(NUM_WEIGHTS)-1:0] weight_addr,
    output logic                          done
);

    localparam int CNT_W = $clog2(NUM_WEIGHTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WEIGHTS - 1);

    ctrl_state_t       state;
    ctrl_state_t       next_state;
    logic [CNT_W-1:0]  weight_cnt;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = event_received ? WRITE : IDLE;
            WRITE:   next_state = (weight_cnt == LAST_CNT) ? DONE : WRITE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter wraps to zero naturally on the last weight because NUM_WEIGHTS is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            weight_cnt <= '0;
            addr_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    weight_cnt <= '0;
                    if (event_received) begin
                        addr_q <= event_addr;
                    end
                end
                WRITE:   weight_cnt <= weight_cnt + CNT_W'(1);
                default: weight_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        event_ready = 1'b0;
        weight_w_en = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:    event_ready = 1'b1;
            WRITE:   weight_w_en = 1'b1;
            DONE:    done        = 1'b1;
            default: ;
        endcase
    end

    assign weight_addr = {addr_q, weight_cnt};

endmodule

// File: tb/tb_snn_event_controller.sv
// Directed self-checking bench for snn_event_controller with hand-computed expectations.
module tb_snn_event_controller;

    localparam int ADDR_W      = 4;
    localparam int NUM_WEIGHTS = 8;
    localparam int WADDR_W     = ADDR_W + 3;

    logic               clock;
    logic               reset;
    logic [ADDR_W-1:0]  event_addr;
    logic               event_received;
    logic               event_ready;
    logic               weight_w_en;
    logic [WADDR_W-1:0] weight_addr;
    logic               done;

    int compared   = 0;
    int mismatched = 0;

    snn_event_controller #(
        .ADDR_W      (ADDR_W),
        .NUM_WEIGHTS (NUM_WEIGHTS)
    ) uut (
        .clock          (clock),
        .reset          (reset),
        .event_addr     (event_addr),
        .event_received (event_received),
        .event_ready    (event_ready),
        .weight_w_en    (weight_w_en),
        .weight_addr    (weight_addr),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ev, input logic [ADDR_W-1:0] addr);
        reset          = rst;
        event_received = ev;
        event_addr     = addr;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkCycle(input string tag, input int exp_state, input logic exp_wen,
                              input logic exp_done, input int exp_addr);
        checkOutput({tag, ".state"}, 32'(uut.state), exp_state);
        checkOutput({tag, ".w_en"},  32'(weight_w_en), 32'(exp_wen));
        checkOutput({tag, ".done"},  32'(done), 32'(exp_done));
        checkOutput({tag, ".ready"}, 32'(event_ready), 32'(exp_state == 0));
        if (exp_state == 1) begin
            checkOutput({tag, ".addr"}, 32'(weight_addr), exp_addr);
        end
    endtask

    // One full sweep starting from the first WRITE cycle already sampled at entry.
    task automatic checkSweep(input string tag, input int row_base);
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (i > 0) step();
            checkCycle(tag, 1, 1'b1, 1'b0, row_base + i);
            checkOutput({tag, ".cnt"}, 32'(uut.weight_cnt), i);
        end
        step();
        checkCycle({tag, "_done"}, 2, 1'b0, 1'b1, 0);
        checkOutput({tag, "_done.cnt"}, 32'(uut.weight_cnt), 0);
        step();
        checkCycle({tag, "_idle"}, 0, 1'b0, 1'b0, 0);
        checkOutput({tag, "_idle.cnt"}, 32'(uut.weight_cnt), 0);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 4'd3);

        // 1: reset held with event asserted
        for (int i = 0; i < 2; i++) begin
            step();
            checkCycle("reset", 0, 1'b0, 1'b0, 0);
            checkOutput("reset.cnt", 32'(uut.weight_cnt), 0);
            checkOutput("reset.addr", 32'(weight_addr), 0);
        end

        // 2: event held high on address 3, two back-to-back sweeps (period 10)
        applyStimulus(1'b0, 1'b1, 4'd3);
        for (int e = 0; e < 2; e++) begin
            step();
            checkSweep("held", 'h18);
        end
        event_received = 1'b0;
        step();
        checkCycle("held_stop", 0, 1'b0, 1'b0, 0);

        // 3: single one-cycle event on address 5
        applyStimulus(1'b0, 1'b1, 4'd5);
        step();
        event_received = 1'b0;
        checkSweep("single", 'h28);
        for (int i = 0; i < 5; i++) begin
            step();
            checkCycle("single_quiet", 0, 1'b0, 1'b0, 0);
        end

        // 4: address change and event pulse during WRITE are ignored
        applyStimulus(1'b0, 1'b1, 4'd2);
        step();
        event_received = 1'b0;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (i > 0) step();
            checkCycle("ignore", 1, 1'b1, 1'b0, 'h10 + i);
            if (i == 2) begin
                event_addr     = 4'd9;
                event_received = 1'b1;
            end
            if (i == 4) event_received = 1'b0;
        end
        step();
        checkCycle("ignore_done", 2, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkCycle("ignore_quiet", 0, 1'b0, 1'b0, 0);
        end

        // 5: reset mid-sweep at weight_cnt == 4
        applyStimulus(1'b0, 1'b1, 4'd6);
        step();
        event_received = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checkOutput("midrst.pre_cnt", 32'(uut.weight_cnt), 4);
        checkOutput("midrst.pre_addr", 32'(weight_addr), 'h34);
        reset = 1'b1;
        step();
        checkCycle("midrst", 0, 1'b0, 1'b0, 0);
        checkOutput("midrst.cnt", 32'(uut.weight_cnt), 0);
        checkOutput("midrst.addr", 32'(weight_addr), 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checkCycle("midrst_quiet", 0, 1'b0, 1'b0, 0);
        end

        // 6: top address row and counter wrap
        applyStimulus(1'b0, 1'b1, 4'd15);
        step();
        event_received = 1'b0;
        checkSweep("top", 'h78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
